// File: rtl/rbs_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : rbs_pkg                                                      |
// | Purpose : Shared types and constants for the sequential ripple-borrow  |
// |           subtractor: FSM state encoding, default sizes and helpers    |
// |           for slice count and counter width.                           |
// | Ports   : none (package)                                               |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
package rbs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } rbs_state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 4;

  // Number of SLICE-bit chunks making up one WIDTH-bit operand.
  function automatic int nslice(input int width, input int slice);
    return width / slice;
  endfunction

  // Slice counter width; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : rbs_pkg
`default_nettype wire

// File: rtl/rbs_slice.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : rbs_slice                                                    |
// | Purpose : Combinational W-bit ripple-borrow subtractor built from      |
// |           full-subtractor cells: {bout, d} = a - b - bin.              |
// | Ports   : a, b   [W-1:0] operands (minuend, subtrahend)                |
// |           bin            borrow-in                                     |
// |           d      [W-1:0] difference                                    |
// |           bout           borrow-out                                    |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module rbs_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] d,
  output logic         bout
);

  logic [W:0] chain;

  assign chain[0] = bin;

  for (genvar i = 0; i < W; i++) begin : g_cell
    // Full subtractor: borrow out when a < b + borrow_in at this bit.
    assign d[i]       = a[i] ^ b[i] ^ chain[i];
    assign chain[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & chain[i]);
  end

  assign bout = chain[W];

endmodule : rbs_slice
`default_nettype wire

// File: rtl/rbs_seq_32bit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : rbs_seq_32bit                                                |
// | Purpose : Multi-cycle ripple-borrow subtractor. Computes               |
// |           {b_out, diff} = A - B - b_in (unsigned), SLICE bits per      |
// |           clock, LSB slice first, with valid/ready on both sides.      |
// | Ports   : clk, rst (async, active-high)                                |
// |           in_valid / in_ready   operand handshake                      |
// |           A, B [WIDTH-1:0], b_in operands and borrow-in                |
// |           out_valid / out_ready result handshake                       |
// |           diff [WIDTH-1:0], b_out registered result and final borrow   |
// |           ovf  two's-complement overflow (only with RBS_SIGNED_OVF_EN) |
// | Options : RBS_SIGNED_OVF_EN adds the registered ovf output.            |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module rbs_seq_32bit
  import rbs_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
`ifdef RBS_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = nslice(WIDTH, SLICE);
  localparam int CNT_W  = cnt_width(NSLICE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

  rbs_state_t state, state_next;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             brw;

  logic [SLICE-1:0] a_slice;
  logic [SLICE-1:0] b_slice;
  logic [SLICE-1:0] d_slice;
  logic             brw_next;

  logic accept;
  logic last_slice;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // Back to IDLE only; a new operand is accepted one cycle later.
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept     = (state == IDLE) && in_valid;
  assign last_slice = (cnt == LAST);

  // ---------------------------------------------------------------------
  // Select the current operand slice from the registered copies.
  // ---------------------------------------------------------------------
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (cnt == CNT_W'(k)) begin
        a_slice = a_reg[k*SLICE +: SLICE];
        b_slice = b_reg[k*SLICE +: SLICE];
      end
    end
  end

  rbs_slice #(
    .W (SLICE)
  ) u_slice (
    .a    (a_slice),
    .b    (b_slice),
    .bin  (brw),
    .d    (d_slice),
    .bout (brw_next)
  );

  // ---------------------------------------------------------------------
  // Datapath: operands, running borrow, slice counter and results.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      a_reg <= '0;
      b_reg <= '0;
      brw   <= 1'b0;
      diff  <= '0;
      b_out <= 1'b0;
    end else if (accept) begin
      a_reg <= A;
      b_reg <= B;
      brw   <= b_in;
      cnt   <= '0;
    end else if (state == BUSY) begin
      for (int k = 0; k < NSLICE; k++) begin
        if (cnt == CNT_W'(k)) diff[k*SLICE +: SLICE] <= d_slice;
      end
      brw <= brw_next;
      cnt <= cnt + CNT_W'(1);
      if (last_slice) b_out <= brw_next;
    end
  end

`ifdef RBS_SIGNED_OVF_EN
  // Signed overflow: operand signs differ and the result sign differs from
  // the minuend. The result MSB is the top bit of the final slice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if ((state == BUSY) && last_slice) begin
      ovf <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
             (d_slice[SLICE-1] != a_reg[WIDTH-1]);
    end
  end
`endif

endmodule : rbs_seq_32bit
`default_nettype wire

// File: tb/tb_rbs_seq_32bit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_rbs_seq_32bit                                             |
// | Purpose : Directed self-checking bench for rbs_seq_32bit with          |
// |           hand-computed expected results.                              |
// | Ports   : none                                                         |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_rbs_seq_32bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        b_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        b_out;
`ifdef RBS_SIGNED_OVF_EN
  logic        ovf;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rbs_seq_32bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .b_out     (b_out)
`ifdef RBS_SIGNED_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // Present one operand set, then count rising edges until out_valid.
  // Operand inputs are scrambled after acceptance; they must be ignored.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic bin, output int lat);
    @(negedge clk);
    A = a; B = b; b_in = bin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = 32'hDEAD_BEEF; B = 32'h0BAD_F00D; b_in = ~bin;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Consume the result and confirm return to IDLE.
  task automatic consume(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_consume: out_valid=%b in_ready=%b, need 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic check_result(input string name, input int lat,
                              input logic [31:0] exp_d, input logic exp_b);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges, need 8", name, lat);
    end
    checks++;
    if (diff !== exp_d) begin
      errors++;
      $display("FAIL %s_diff: got %h, need %h", name, diff, exp_d);
    end
    checks++;
    if (b_out !== exp_b) begin
      errors++;
      $display("FAIL %s_b_out: got %b, need %b", name, b_out, exp_b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; b_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 32'h0 || b_out !== 1'b0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b diff=%h b_out=%b, need 1/0/0/0",
               in_ready, out_valid, diff, b_out);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    run_op(32'h0000_0010, 32'h0000_0001, 1'b0, lat);
    check_result("basic", lat, 32'h0000_000F, 1'b0);
    consume("basic");
  endtask

  task automatic test_borrow_ripple();
    int lat;
    run_op(32'h0000_0000, 32'h0000_0001, 1'b0, lat);
    check_result("ripple_b", lat, 32'hFFFF_FFFF, 1'b1);
    consume("ripple_b");
    run_op(32'h0000_0000, 32'h0000_0000, 1'b1, lat);
    check_result("ripple_bin", lat, 32'hFFFF_FFFF, 1'b1);
    consume("ripple_bin");
  endtask

  task automatic test_equal_borrow();
    int lat;
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, lat);
    check_result("equal_bin", lat, 32'hFFFF_FFFF, 1'b1);
    consume("equal_bin");
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(32'h1234_5678, 32'h0000_0009, 1'b0, lat);
    check_result("bp", lat, 32'h1234_566F, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          diff !== 32'h1234_566F || b_out !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b diff=%h b_out=%b, need 1/0/1234566f/0",
                 i, out_valid, in_ready, diff, b_out);
      end
    end
    consume("bp");
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    A = 32'hFFFF_FFFF; B = 32'h1234_5678; b_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Three slices done; now working on slice 3.
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || diff !== 32'h0 || in_ready !== 1'b1 || b_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: out_valid=%b diff=%h in_ready=%b b_out=%b, need 0/0/1/0",
               out_valid, diff, in_ready, b_out);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(32'h0000_0005, 32'h0000_0003, 1'b0, lat);
    check_result("after_rst", lat, 32'h0000_0002, 1'b0);
    consume("after_rst");
  endtask

`ifdef RBS_SIGNED_OVF_EN
  task automatic test_ovf();
    int lat;
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, lat);
    check_result("ovf_neg", lat, 32'h7FFF_FFFF, 1'b0);
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_neg_flag: got %b, need 1", ovf);
    end
    consume("ovf_neg");
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
    check_result("ovf_pos", lat, 32'h8000_0000, 1'b1);
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_pos_flag: got %b, need 1", ovf);
    end
    consume("ovf_pos");
    run_op(32'h0000_0005, 32'h0000_0003, 1'b0, lat);
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_none_flag: got %b, need 0", ovf);
    end
    consume("ovf_none");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_borrow_ripple();
    test_equal_borrow();
    test_backpressure();
    test_reset_mid();
`ifdef RBS_SIGNED_OVF_EN
    test_ovf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rbs_seq_32bit
`default_nettype wire

// File: doc/rbs_seq_32bit.md
Name: rbs_seq_32bit

Overview:
- Multi-cycle ripple-borrow subtractor: computes {b_out, diff} = A - B - b_in, unsigned, one SLICE-bit chunk per clock, LSB slice first.
- Serves as the subtract-side counterpart to the combinational ripple-carry adder chain in the datapath.
- Valid/ready handshake on both sides.
- Trades latency for a single SLICE-wide borrow chain.

Parameters:
- WIDTH, 32: operand and result width.
- SLICE, 4: bits processed per cycle. Must divide WIDTH exactly; NSLICE = WIDTH/SLICE.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands (high only in IDLE).
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- b_in  input  1  borrow-in.
- out_valid  output  1  result valid; held until consumed.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  difference, registered.
- b_out  output  1  final borrow, registered; 1 iff A < B + b_in (unsigned).

Behaviour:
- Reset: one clock, clk; reset rst is asynchronous, active-high.
- Reset values: state=IDLE, slice counter=0, diff=0, b_out=0, out_valid=0. in_ready=1, decoded from IDLE.
- Reset mid-operation: aborts the subtraction, returns to IDLE and clears all registers. No result is emitted.

States:
- IDLE: in_ready=1. On in_valid&&in_ready, capture A, B, b_in into operand regs; borrow reg <= b_in; cnt <= 0; go to BUSY.
- BUSY: in_ready=0, out_valid=0.
  - Each cycle, slice k=cnt: {brw', d} = A[k] - B[k] - brw, computed with SLICE+1-bit arithmetic. brw'=1 iff A[k] < B[k] + brw.
  - diff[k*SLICE +: SLICE] <= d; brw <= brw'; cnt <= cnt+1.
  - When cnt==NSLICE-1, also b_out <= brw' and go to DONE.
- DONE: out_valid=1. diff and b_out stay stable while out_valid && !out_ready.
  - On out_ready, go to IDLE. in_ready rises the next cycle; there is no same-cycle accept from DONE.

Timing and data rules:
- Latency: out_valid rises NSLICE rising edges after the accepting edge (8 at defaults).
- Throughput: one operation per NSLICE+2 cycles at best.
- In BUSY, diff holds partially updated slices. It is defined only while out_valid=1.
- Input changes while not in IDLE are ignored; operands are taken only from the registered copies.
- Wrap-around: a negative result wraps modulo 2^WIDTH and b_out=1.
- out_ready asserted outside DONE has no effect.

Optional Feature:
- Macro RBS_SIGNED_OVF_EN.
- Defined: adds output port ovf (1 bit), registered with b_out, reset 0. ovf = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]), i.e. two's-complement overflow of A-B-b_in.
- Not defined: the port and its logic are absent; the block is unsigned-only.

Decomposition:
- Shared package rbs_pkg:
  - State enum {IDLE, BUSY, DONE}, 2 bits.
  - Default WIDTH/SLICE constants.
  - Localparam function computing NSLICE and the counter width clog2(NSLICE).
- One natural sub-module, rbs_slice: combinational SLICE-bit ripple-borrow subtractor built from full-subtractor cells. Inputs: a, b, bin. Outputs: d, bout.
- Top module holds the FSM, counter, operand, borrow and result registers.

Test Plan:
- Basic: A=0x0000_0010, B=0x0000_0001, b_in=0 -> diff=0x0000_000F, b_out=0, out_valid exactly 8 edges after accept.
- Full borrow ripple: A=0x0000_0000, B=0x0000_0001, b_in=0 -> diff=0xFFFF_FFFF, b_out=1. With b_in=1 and B=0 -> same result.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, diff and b_out stable, in_ready=0. Assert out_ready -> IDLE, then in_ready=1 the next cycle.
- Reset mid-BUSY: assert rst asynchronously at slice 3 of A=0xFFFF_FFFF, B=0x1234_5678 -> immediately out_valid=0, diff=0, in_ready=1. Next operation A=5, B=3 -> diff=2, b_out=0.
- Equal operands with borrow: A=B=0x8000_0000, b_in=1 -> diff=0xFFFF_FFFF, b_out=1.
- RBS_SIGNED_OVF_EN: A=0x8000_0000, B=0x0000_0001 -> diff=0x7FFF_FFFF, ovf=1, b_out=0. A=0x7FFF_FFFF, B=0xFFFF_FFFF -> diff=0x8000_0000, ovf=1, b_out=1.
